// File: rtl/subtrator_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package subtrator_serial_pkg;
    localparam int N_DEF = 8;

    // The unused encoding 2'd3 falls back to OCIOSO in the FSM default branch.
    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        FIM     = 2'd2
    } estado_t;
endpackage

// File: rtl/subtrator_serial_if.sv
// Start/ready handshake and operand/result bus for subtrator_serial.
// OVF is present only when SUBTRATOR_OVERFLOW_EN is defined.
interface subtrator_serial_if #(parameter int N = 8);
    logic         inicio;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         ocupado;
    logic         pronto;
    logic [N-1:0] D;
    logic         BOUT;
`ifdef SUBTRATOR_OVERFLOW_EN
    logic         OVF;

    modport master (output inicio, A, B, input ocupado, pronto, D, BOUT, OVF);
    modport slave  (input inicio, A, B, output ocupado, pronto, D, BOUT, OVF);
`else
    modport master (output inicio, A, B, input ocupado, pronto, D, BOUT);
    modport slave  (input inicio, A, B, output ocupado, pronto, D, BOUT);
`endif
endinterface

// File: rtl/subtrator_serial_completo.sv
// Combinational 1-bit full subtractor: {bout,d} = a - b - bin.
module subtrator_completo (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial N-bit subtractor D = A - B, LSB first, one bit per clock behind inicio/pronto.
// Optional signed-overflow flag OVF enabled by SUBTRATOR_OVERFLOW_EN.
module subtrator_serial
    import subtrator_serial_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic               clk,
    input  logic               rst,
    subtrator_serial_if.slave  bus
);
    localparam int CW = $clog2(N);

    estado_t         r_estado;
    logic [N-1:0]    r_sa;
    logic [N-1:0]    r_sb;
    logic            r_borrow;
    logic [CW-1:0]   r_cont;
    logic [N-1:0]    r_d;
    logic            r_bout;
    logic            r_ocupado;
    logic            r_pronto;
    logic            w_d;
    logic            w_bo;
    logic            w_ultimo;

    subtrator_completo u_fs (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bo)
    );

    assign w_ultimo = (r_cont == CW'(N - 1));

`ifdef SUBTRATOR_OVERFLOW_EN
    // Operand sign bits are kept apart because r_sa/r_sb are consumed by shifting.
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_estado == OCIOSO && bus.inicio) begin
            r_a_msb <= bus.A[N-1];
            r_b_msb <= bus.B[N-1];
            r_ovf   <= 1'b0;
        end else if (r_estado == CALCULA && w_ultimo) begin
            r_ovf   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
        end
    end

    assign bus.OVF = r_ovf;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado  <= OCIOSO;
            r_sa      <= '0;
            r_sb      <= '0;
            r_borrow  <= 1'b0;
            r_cont    <= '0;
            r_d       <= '0;
            r_bout    <= 1'b0;
            r_ocupado <= 1'b0;
            r_pronto  <= 1'b0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    r_pronto <= 1'b0;
                    if (bus.inicio) begin
                        r_sa      <= bus.A;
                        r_sb      <= bus.B;
                        r_borrow  <= 1'b0;
                        r_cont    <= '0;
                        r_ocupado <= 1'b1;
                        r_estado  <= CALCULA;
                    end
                end
                CALCULA: begin
                    r_d      <= {w_d, r_d[N-1:1]};
                    r_sa     <= r_sa >> 1;
                    r_sb     <= r_sb >> 1;
                    r_borrow <= w_bo;
                    r_cont   <= r_cont + CW'(1);
                    if (w_ultimo) begin
                        r_bout   <= w_bo;
                        r_pronto <= 1'b1;
                        r_estado <= FIM;
                    end
                end
                FIM: begin
                    r_pronto  <= 1'b0;
                    r_ocupado <= 1'b0;
                    r_estado  <= OCIOSO;
                end
                default: begin
                    r_pronto  <= 1'b0;
                    r_ocupado <= 1'b0;
                    r_estado  <= OCIOSO;
                end
            endcase
        end
    end

    assign bus.ocupado = r_ocupado;
    assign bus.pronto  = r_pronto;
    assign bus.D       = r_d;
    assign bus.BOUT    = r_bout;
endmodule
